// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column strobe rotation, 2-FF row synchroniser,
// full-scan classification, press/release debounce FSM and a small
// key-event FIFO with a valid/ready pop port.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV       = 65536,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fila,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ready,
   output logic       any_pressed,
   output logic       overflow
);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

   logic [3:0]    fila_m, fila_s;
   logic [DW-1:0] divider;
   logic [1:0]    col_idx;
   logic [1:0]    acc_cnt;
   logic [3:0]    acc_code;
   logic [2:0]    pc, tot;
   logic [1:0]    row_enc;
   logic [3:0]    one_code;
   logic          tick, scan_end, res_one, res_none;
   state_t        state;
   logic [3:0]    cand;
   logic [CW-1:0] cnt;
   logic          push_req, pop, full, do_push;
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [3:0]    last_code;

   // two-stage synchroniser on the asynchronous row inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         fila_m <= '0;
         fila_s <= '0;
      end else begin
         fila_m <= fila;
         fila_s <= fila_m;
      end
   end

   assign tick     = (divider == DW'(SCAN_DIV - 1));
   assign scan_end = tick && (col_idx == 2'd3);

   // divider and one-hot column rotation
   always_ff @(posedge clk) begin
      if (rst) begin
         divider <= '0;
         col     <= 4'b0001;
         col_idx <= 2'd0;
      end else if (tick) begin
         divider <= '0;
         col     <= {col[2:0], col[3]};
         col_idx <= col_idx + 2'd1;
      end else begin
         divider <= divider + DW'(1);
      end
   end

   // classify the current column sample and merge it with the running scan
   always_comb begin
      pc      = 3'd0;
      row_enc = 2'd0;
      for (int r = 0; r < 4; r++) begin
         pc = pc + {2'b00, fila_s[r]};
         if (fila_s[r]) row_enc = 2'(r);
      end
      tot      = {1'b0, acc_cnt} + pc;
      res_none = (tot == 3'd0);
      res_one  = (tot == 3'd1);
      one_code = (pc == 3'd1) ? {col_idx, row_enc} : acc_code;
   end

   // per-scan hit accumulator; count saturates at 2 (anything >1 is MULTI)
   always_ff @(posedge clk) begin
      if (rst || scan_end) begin
         acc_cnt  <= 2'd0;
         acc_code <= 4'd0;
      end else if (tick) begin
         acc_cnt  <= (tot > 3'd2) ? 2'd2 : tot[1:0];
         acc_code <= one_code;
      end
   end

   // an event is produced on the scan that completes the press debounce
   always_comb begin
      push_req = 1'b0;
      if (scan_end && res_one) begin
         if (state == IDLE && DEBOUNCE_SCANS == 1) push_req = 1'b1;
         if (state == DEBOUNCE && one_code == cand &&
             (cnt + CW'(1)) == CW'(DEBOUNCE_SCANS)) push_req = 1'b1;
      end
   end

   // debounce FSM, advanced once per full scan
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cand        <= 4'd0;
         cnt         <= '0;
         any_pressed <= 1'b0;
      end else begin
         any_pressed <= (state == HELD) || (state == RELEASE);
         if (scan_end) begin
            case (state)
               IDLE: if (res_one) begin
                  cand  <= one_code;
                  cnt   <= CW'(1);
                  state <= (DEBOUNCE_SCANS == 1) ? HELD : DEBOUNCE;
               end
               DEBOUNCE: if (res_one && one_code == cand) begin
                  cnt <= cnt + CW'(1);
                  if ((cnt + CW'(1)) == CW'(DEBOUNCE_SCANS)) state <= HELD;
               end else if (res_one) begin
                  cand <= one_code;
                  cnt  <= CW'(1);
               end else begin
                  state <= IDLE;
               end
               HELD: if (res_none) begin
                  cnt   <= CW'(1);
                  state <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
               end
               RELEASE: if (res_none) begin
                  cnt <= cnt + CW'(1);
                  if ((cnt + CW'(1)) == CW'(DEBOUNCE_SCANS)) state <= IDLE;
               end else begin
                  state <= HELD;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign key_valid = (count != '0);
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pop       = key_valid && key_ready;
   assign do_push   = push_req && (!full || pop);
   assign key_code  = key_valid ? mem[rd_ptr] : last_code;

   // FIFO storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= one_code;
   end

   // FIFO pointers, occupancy, last-popped head and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_code <= 4'd0;
         overflow  <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            last_code <= mem[rd_ptr];
         end
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (push_req && full && !pop) overflow <= 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=2,
// FIFO_DEPTH=4 (one full scan = 16 clk cycles).
module tb_keypad_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fila;
   logic [3:0] col;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       any_pressed;
   logic       overflow;

   logic [15:0] keys;       // keys[{col_idx,row_idx}] = pressed
   logic [3:0]  popped[$];  // codes seen leaving the FIFO
   int          checks = 0;
   int          errors = 0;

   keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .fila(fila), .col(col), .key_valid(key_valid),
      .key_code(key_code), .key_ready(key_ready), .any_pressed(any_pressed),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // keypad matrix model: driven column connects pressed keys to the rows
   always_comb begin
      fila = 4'b0000;
      for (int c = 0; c < 4; c++)
         if (col[c]) fila = fila | keys[4*c +: 4];
   end

   // record every handshake that pops the FIFO
   always @(negedge clk)
      if (!rst && key_valid && key_ready) popped.push_back(key_code);

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // wait until col has just rotated into 0001 (start of a scan)
   task automatic align;
      logic [3:0] prev;
      int k;
      prev = col;
      k = 0;
      @(negedge clk);
      while (!(col == 4'b0001 && prev == 4'b1000) && k < 64) begin
         prev = col;
         @(negedge clk);
         k++;
      end
      if (k >= 64) begin
         errors++;
         $display("FAIL align: col stuck at %b, required rotation to 0001", col);
      end
   endtask

   task automatic press(input int code, input int scans_on, input int scans_off);
      align();
      keys = 16'h0;
      keys[code] = 1'b1;
      cyc(16 * scans_on);
      keys = 16'h0;
      cyc(16 * scans_off);
   endtask

   task automatic test_reset;
      logic [3:0] exp_col [4];
      exp_col[0] = 4'b0010; exp_col[1] = 4'b0100;
      exp_col[2] = 4'b1000; exp_col[3] = 4'b0001;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      checks++;
      if (col !== 4'b0001 || key_valid !== 1'b0 || any_pressed !== 1'b0 ||
          overflow !== 1'b0 || key_code !== 4'd0) begin
         errors++;
         $display("FAIL reset: col=%b kv=%b ap=%b ov=%b kc=%h, required 0001 0 0 0 0",
                  col, key_valid, any_pressed, overflow, key_code);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(4);
         checks++;
         if (col !== exp_col[i]) begin
            errors++;
            $display("FAIL col_step%0d: col=%b, required %b", i, col, exp_col[i]);
         end
      end
   endtask

   task automatic test_clean_press;
      int n0;
      n0 = popped.size();
      key_ready = 1'b1;
      align();
      keys = 16'h0;
      keys[6] = 1'b1;           // col 1, row 2 -> fila=0100 while col=0010
      cyc(48);
      checks++;
      if (any_pressed !== 1'b1) begin
         errors++;
         $display("FAIL clean_held: any_pressed=%b, required 1", any_pressed);
      end
      keys = 16'h0;
      cyc(24);                  // one empty scan seen: still in RELEASE
      checks++;
      if (any_pressed !== 1'b1) begin
         errors++;
         $display("FAIL clean_release1: any_pressed=%b, required 1", any_pressed);
      end
      cyc(16);                  // second empty scan: back to IDLE
      checks++;
      if (any_pressed !== 1'b0) begin
         errors++;
         $display("FAIL clean_release2: any_pressed=%b, required 0", any_pressed);
      end
      checks++;
      if (popped.size() - n0 != 1) begin
         errors++;
         $display("FAIL clean_count: events=%0d, required 1", popped.size() - n0);
      end else begin
         checks++;
         if (popped[n0] !== 4'b0110) begin
            errors++;
            $display("FAIL clean_code: code=%b, required 0110", popped[n0]);
         end
      end
   endtask

   task automatic test_bounce;
      int n0;
      logic saw_ap;
      n0 = popped.size();
      saw_ap = 1'b0;
      align();
      keys = 16'h0;
      keys[6] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         saw_ap = saw_ap | any_pressed;
      end
      keys = 16'h0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         saw_ap = saw_ap | any_pressed;
      end
      checks++;
      if (popped.size() != n0 || saw_ap !== 1'b0) begin
         errors++;
         $display("FAIL bounce: events=%0d any_pressed_seen=%b, required 0 0",
                  popped.size() - n0, saw_ap);
      end
   endtask

   task automatic test_hold_repress;
      int n0;
      n0 = popped.size();
      key_ready = 1'b1;
      press(9, 20, 3);
      press(9, 3, 3);
      checks++;
      if (popped.size() - n0 != 2) begin
         errors++;
         $display("FAIL hold_count: events=%0d, required 2", popped.size() - n0);
      end else begin
         checks++;
         if (popped[n0] !== 4'd9 || popped[n0+1] !== 4'd9) begin
            errors++;
            $display("FAIL hold_code: codes=%h %h, required 9 9",
                     popped[n0], popped[n0+1]);
         end
      end
   endtask

   task automatic test_overflow;
      int n0;
      logic [3:0] exp_q [4];
      exp_q[0] = 4'd0; exp_q[1] = 4'd5; exp_q[2] = 4'd10; exp_q[3] = 4'd15;
      key_ready = 1'b0;
      n0 = popped.size();
      press(0, 3, 3);
      press(5, 3, 3);
      press(10, 3, 3);
      press(15, 3, 3);
      checks++;
      if (overflow !== 1'b0 || key_valid !== 1'b1 || key_code !== 4'd0) begin
         errors++;
         $display("FAIL ovf_full: ov=%b kv=%b kc=%h, required 0 1 0",
                  overflow, key_valid, key_code);
      end
      press(3, 3, 3);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: overflow=%b, required 1", overflow);
      end
      key_ready = 1'b1;
      cyc(6);
      checks++;
      if (popped.size() - n0 != 4) begin
         errors++;
         $display("FAIL ovf_count: pops=%0d, required 4", popped.size() - n0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (popped[n0+i] !== exp_q[i]) begin
               errors++;
               $display("FAIL ovf_order%0d: code=%h, required %h",
                        i, popped[n0+i], exp_q[i]);
            end
         end
      end
      checks++;
      if (key_valid !== 1'b0 || key_code !== 4'd15 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drained: kv=%b kc=%h ov=%b, required 0 f 1",
                  key_valid, key_code, overflow);
      end
   endtask

   task automatic test_multi_and_reset;
      int n0;
      n0 = popped.size();
      key_ready = 1'b1;
      align();
      keys = 16'h0;
      keys[0] = 1'b1;           // col 0, rows 0 and 3 together
      keys[3] = 1'b1;
      cyc(64);
      keys = 16'h0;
      cyc(48);
      checks++;
      if (popped.size() != n0 || any_pressed !== 1'b0) begin
         errors++;
         $display("FAIL multi: events=%0d ap=%b, required 0 0",
                  popped.size() - n0, any_pressed);
      end
      // valid key for one scan puts the FSM in DEBOUNCE, then reset
      align();
      keys[12] = 1'b1;
      cyc(20);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      checks++;
      if (col !== 4'b0001 || overflow !== 1'b0 || key_valid !== 1'b0 ||
          any_pressed !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: col=%b ov=%b kv=%b ap=%b, required 0001 0 0 0",
                  col, overflow, key_valid, any_pressed);
      end
      // a stale candidate would make one more scan of the key produce an event
      keys = 16'h0;
      align();
      keys[12] = 1'b1;
      cyc(16);
      keys = 16'h0;
      cyc(48);
      checks++;
      if (popped.size() != n0) begin
         errors++;
         $display("FAIL rst_discard: events=%0d, required 0", popped.size() - n0);
      end
   endtask

   initial begin
      rst = 1'b1;
      keys = 16'h0;
      key_ready = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold_repress();
      test_overflow();
      test_multi_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
